// File: rtl/line_rasterizer_if.sv
// line_rasterizer_if: command and pixel-write bundle for the rasterizer.
// master issues segments/clears; slave draws and emits pixel writes.
interface line_rasterizer_if #(
  parameter int COORD_W = 16
);
  logic               clear_req;
  logic               line_valid;
  logic               line_ready;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               pix_we;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_data;
  logic               busy;
  logic               done;

  modport master (
    output clear_req, line_valid, x0, y0, x1, y1,
    input  line_ready, pix_we, pix_x, pix_y,
    input  pix_data, busy, done
  );

  modport slave (
    input  clear_req, line_valid, x0, y0, x1, y1,
    output line_ready, pix_we, pix_x, pix_y,
    output pix_data, busy, done
  );
endinterface

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham segment drawer plus full framebuffer clear.
// One pixel write per cycle; pixels beyond 0..SIZE are stepped but not written.
module line_rasterizer #(
  parameter int SIZE    = 10,
  parameter int COORD_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  line_rasterizer_if.slave bus
);
  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] LIM = COORD_W'(SIZE);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  typedef enum logic [1:0] {IDLE, CLEAR, SETUP, DRAW} state_e;

  state_e state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic sxn_q, sxn_d, syn_q, syn_d;
  logic done_q, done_d;

  logic [COORD_W-1:0] adx, ady;
  logic signed [EW-1:0] e2, add_x, add_y;
  logic step_x, step_y, at_end, in_fb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      err_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sxn_q   <= sxn_d;
      syn_q   <= syn_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    err_d   = err_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sxn_d   = sxn_q;
    syn_d   = syn_q;
    done_d  = 1'b0;

    adx    = (x1_q >= x_q) ? x1_q - x_q : x_q - x1_q;
    ady    = (y1_q >= y_q) ? y1_q - y_q : y_q - y1_q;
    e2     = err_q <<< 1;
    step_x = (e2 >= dy_q);
    step_y = (e2 <= dx_q);
    add_x  = step_x ? dy_q : EW'(0);
    add_y  = step_y ? dx_q : EW'(0);
    at_end = (x_q == x1_q) && (y_q == y1_q);

    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
        end else if (bus.line_valid) begin
          x_d     = bus.x0;
          y_d     = bus.y0;
          x1_d    = bus.x1;
          y1_d    = bus.y1;
          state_d = SETUP;
        end
      end
      CLEAR: begin
        if (cx_q == LIM) begin
          cx_d = '0;
          if (cy_q == LIM) begin
            cy_d    = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + ONE;
          end
        end else begin
          cx_d = cx_q + ONE;
        end
      end
      SETUP: begin
        dx_d    = $signed({2'b00, adx});
        dy_d    = -$signed({2'b00, ady});
        err_d   = dx_d + dy_d;
        sxn_d   = (x1_q < x_q);
        syn_d   = (y1_q < y_q);
        state_d = DRAW;
      end
      DRAW: begin
        if (at_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          // both axis updates share one e2 and land together in err
          err_d = err_q + add_x + add_y;
          if (step_x) x_d = sxn_q ? x_q - ONE : x_q + ONE;
          if (step_y) y_d = syn_q ? y_q - ONE : y_q + ONE;
        end
      end
    endcase
  end

  assign in_fb = (x_q <= LIM) && (y_q <= LIM);

  always_comb begin
    bus.pix_we   = 1'b0;
    bus.pix_x    = '0;
    bus.pix_y    = '0;
    bus.pix_data = 1'b0;
    if (state_q == CLEAR) begin
      bus.pix_we = 1'b1;
      bus.pix_x  = cx_q;
      bus.pix_y  = cy_q;
    end else if (state_q == DRAW) begin
      bus.pix_we   = in_fb;
      bus.pix_x    = x_q;
      bus.pix_y    = y_q;
      bus.pix_data = 1'b1;
    end
  end

  assign bus.line_ready = (state_q == IDLE) && !bus.clear_req;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: table-driven segment vectors plus clear/reset sequences.
// A monitor pops expected pixel writes from a scoreboard queue.
module tb_line_rasterizer;
  localparam int SIZE = 10;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_rasterizer_if #(.COORD_W(CW)) bus ();

  line_rasterizer #(.SIZE(SIZE), .COORD_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int d;
  } pix_t;

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int draws;
    int writes;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[9];

  int checks   = 0;
  int failures = 0;
  int wcnt     = 0;
  int ndone    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    pix_t e;
    if (rst_n) begin
      if (bus.done) ndone++;
      if (bus.pix_we) begin
        wcnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got (%0d,%0d) expected none",
                   bus.pix_x, bus.pix_y);
        end else begin
          e = exp_q.pop_front();
          chk("pix_x", int'(bus.pix_x), e.x);
          chk("pix_y", int'(bus.pix_y), e.y);
          chk("pix_data", int'(bus.pix_data), e.d);
        end
      end
    end
  end

  task automatic push_pix(input int x, input int y, input int d);
    pix_t p;
    p.x = x;
    p.y = y;
    p.d = d;
    exp_q.push_back(p);
  endtask

  // Reference Bresenham over plain integers, with clipping
  task automatic push_line(input int x0, input int y0,
                           input int x1, input int y1);
    int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    int dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    int sx = (x1 >= x0) ? 1 : -1;
    int sy = (y1 >= y0) ? 1 : -1;
    int err = dx + dy;
    int e2;
    int x = x0;
    int y = y0;
    for (int n = 0; n < 2000; n++) begin
      if (x <= SIZE && y <= SIZE) push_pix(x, y, 1);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin
        err += dy;
        x += sx;
      end
      if (e2 <= dx) begin
        err += dx;
        y += sy;
      end
    end
  endtask

  task automatic drive_line(input int x0, input int y0,
                            input int x1, input int y1);
    bus.line_valid = 1'b1;
    bus.x0 = CW'(x0);
    bus.y0 = CW'(y0);
    bus.x1 = CW'(x1);
    bus.y1 = CW'(y1);
  endtask

  task automatic wait_ready(input string nm);
    int ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.line_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk({nm, "_ready_timeout"}, ok, 1);
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the handshake edge, i.e. in cycle 1 (SETUP)
  task automatic wait_line(input string nm, input int draws,
                           input int writes, input int wstart);
    int dc = -1;
    int fc = -1;
    int rdy = 0;
    wcnt = 0;
    bus.line_valid = 1'b0;
    bus.x0 = CW'($urandom_range(0, 65535));
    bus.y0 = CW'($urandom_range(0, 65535));
    bus.x1 = CW'($urandom_range(0, 65535));
    bus.y1 = CW'($urandom_range(0, 65535));
    bus.clear_req = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, "_busy"}, int'(bus.busy), 1);
      if (bus.pix_we && fc < 0) fc = c;
      if (bus.done) begin
        dc = c;
        rdy = int'(bus.line_ready);
        break;
      end
      @(posedge clk);
      #1;
      bus.clear_req = 1'b0;
    end
    bus.clear_req = 1'b0;
    chk({nm, "_done_cycle"}, dc, draws + 2);
    chk({nm, "_ready_at_done"}, rdy, 1);
    chk({nm, "_writes"}, wcnt, writes);
    if (wstart != 0) chk({nm, "_first_write_cycle"}, fc, 2);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_line(input string nm, input vec_t v);
    wait_ready(nm);
    push_line(v.x0, v.y0, v.x1, v.y1);
    drive_line(v.x0, v.y0, v.x1, v.y1);
    @(posedge clk);
    #1;
    wait_line(nm, v.draws, v.writes,
              int'(v.x0 <= SIZE && v.y0 <= SIZE));
  endtask

  initial begin
    int dc;
    int fc;
    int nd;

    vecs[0] = '{0, 0, 3, 0, 4, 4};
    vecs[1] = '{0, 0, 2, 4, 5, 5};
    vecs[2] = '{3, 2, 0, 2, 4, 4};
    vecs[3] = '{5, 5, 5, 5, 1, 1};
    vecs[4] = '{9, 0, 12, 0, 4, 2};
    vecs[5] = '{10, 10, 0, 0, 11, 11};
    vecs[6] = '{2, 9, 7, 1, 9, 9};
    vecs[7] = '{0, 8, 4, 12, 5, 3};
    vecs[8] = '{65535, 65535, 65530, 65533, 6, 0};

    bus.clear_req = 1'b0;
    drive_line(0, 0, 3, 0);
    #12;
    chk("rst_pix_we", int'(bus.pix_we), 0);
    chk("rst_pix_x", int'(bus.pix_x), 0);
    chk("rst_pix_y", int'(bus.pix_y), 0);
    chk("rst_pix_data", int'(bus.pix_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_line_ready", int'(bus.line_ready), 1);

    // handshake on the very first edge after release
    push_line(0, 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_line("first_after_reset", 4, 4, 1);

    // explicit steep pixels, independent of the reference model
    wait_ready("steep");
    push_pix(0, 0, 1);
    push_pix(1, 1, 1);
    push_pix(1, 2, 1);
    push_pix(2, 3, 1);
    push_pix(2, 4, 1);
    drive_line(0, 0, 2, 4);
    @(posedge clk);
    #1;
    wait_line("steep_fixed", 5, 5, 1);

    foreach (vecs[i]) run_line($sformatf("vec%0d", i), vecs[i]);

    // clear has priority over a simultaneous line request
    wait_ready("clear");
    bus.clear_req = 1'b1;
    drive_line(1, 1, 2, 1);
    #1;
    chk("clear_line_ready_low", int'(bus.line_ready), 0);
    for (int yy = 0; yy <= SIZE; yy++)
      for (int xx = 0; xx <= SIZE; xx++)
        push_pix(xx, yy, 0);
    push_line(1, 1, 2, 1);
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    wcnt = 0;
    dc = -1;
    fc = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.pix_we && fc < 0) fc = c;
      if (bus.done) begin
        dc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("clear_done_cycle", dc, (SIZE + 1) * (SIZE + 1) + 1);
    chk("clear_writes", wcnt, (SIZE + 1) * (SIZE + 1));
    chk("clear_first_write_cycle", fc, 1);
    @(posedge clk);
    #1;
    wait_line("after_clear", 2, 2, 1);

    // reset during the third pixel of a horizontal line
    wait_ready("rst_mid");
    push_pix(0, 0, 1);
    push_pix(1, 0, 1);
    drive_line(0, 0, 5, 0);
    @(posedge clk);
    #1;
    bus.line_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pix_we", int'(bus.pix_we), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_done", int'(bus.done), 0);
    nd = ndone;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", ndone, nd);
    chk("rst_mid_idle", int'(bus.busy), 0);
    chk("rst_mid_queue", exp_q.size(), 0);
    exp_q.delete();
    run_line("after_rst_mid", '{1, 3, 4, 5, 4, 4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
